alu_op_scheduler: RTL
=====================

# alu_op_scheduler

Shares one arithmetic unit among NUM_REQ requesters. Each requester presents an operation (A, B, function) on a valid/ready channel. A round-robin arbiter picks one, the FSM sequences the unit's enable/result cycle, and the tagged result is returned on a single response channel with backpressure. The block sits between the command sources and the arithmetic unit. It is the only driver of the unit's operand and enable inputs.

## Interface
Parameters:
- ALU_WIDTH, 16, operand/result width.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must be ≥ clog2(NUM_REQ).

Ports (reset rst, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*ALU_WIDTH  operand A, requester i at bits [i*ALU_WIDTH +: ALU_WIDTH].
- req_b  in  NUM_REQ*ALU_WIDTH  operand B, same packing.
- req_fun  in  NUM_REQ*2  function: 00 add, 01 sub, 10 mul, 11 div.
- alu_a, alu_b  out  ALU_WIDTH  operands to the arithmetic unit (registered).
- alu_fun  out  2  function to the unit (registered).
- alu_enable  out  1  unit enable, single-cycle pulse.
- alu_out  in  ALU_WIDTH  unit result, registered inside the unit.
- alu_flag  in  1  unit result-valid flag, registered inside the unit.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the originating requester.
- rsp_result  out  ALU_WIDTH  result.
- rsp_err  out  1  1 = divide by zero or missing alu_flag.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

IDLE:
- If any req_valid is high, the arbiter grants the first valid index at or after rr_ptr, wrapping.
- req_ready[grant]=1 combinationally in the same cycle; the handshake completes.
- Operands, function and grant id are latched.
- rr_ptr ← (grant+1) mod NUM_REQ.
- Next state is ISSUE, except divide with B==0, which goes directly to RESP with rsp_err=1 and rsp_result=0. The unit is never enabled for divide by zero.

ISSUE:
- alu_enable=1 for exactly this cycle; alu_a/alu_b/alu_fun hold the latched values.
- Next state is WAIT.

WAIT:
- Samples alu_out into rsp_result.
- rsp_err ← ~alu_flag.
- Next state is RESP.

RESP:
- rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable until rsp_ready=1.
- On handshake, next state is IDLE.

General rules:
- req_ready is 0 in every state except IDLE.
- New requests are not accepted until the response handshake completes: at most one operation in flight.
- Width rule: the result is exactly the unit's ALU_WIDTH output. The product and quotient are truncated by the unit; the scheduler does no extension and no carry.
- alu_a, alu_b and alu_fun hold their last values outside ISSUE; alu_enable is 0 outside ISSUE.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, alu_enable=0, alu_a=alu_b=0, alu_fun=00, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
- Reset mid-operation: the in-flight operation is dropped silently; the requester must re-present it. Any unit output arriving after reset is ignored because state=IDLE.
- A requester that drops req_valid before grant is simply not granted. Requests are not sticky.

## Timing
- Accept at cycle T (IDLE).
- alu_enable high at T+1.
- Unit outputs valid and sampled at T+2.
- rsp_valid high from T+3.
- Minimum issue interval is 4 cycles (T+3 handshake → IDLE at T+4).
- Divide by zero: rsp_valid high at T+1.
- rsp_ready high in the first RESP cycle completes the transfer in that cycle.
- rsp_ready held low stalls the block in RESP indefinitely, with outputs stable.
- Simultaneous requests: exactly one grant per IDLE cycle. The round-robin order guarantees each continuously-valid requester is served within NUM_REQ operations.

## Structure
- Shared package alu_sched_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - function codes FUN_ADD=2'b00, FUN_SUB=2'b01, FUN_MUL=2'b10, FUN_DIV=2'b11;
  - default ALU_WIDTH.
- One sub-module, rr_arbiter: combinational grant from req vector and rr_ptr, plus a registered pointer update on an accept strobe. Parameterised by NUM_REQ.
- The FSM, operand registers and response registers live in the top level.

## Test plan
- Single add: req0 A=0x0003 B=0x0005 fun=00, model unit returns 0x0008 with flag=1 → rsp_valid at T+3, rsp_id=0, rsp_result=0x0008, rsp_err=0; alu_enable exactly one cycle at T+1.
- Fairness: all four requesters continuously valid, starting at rr_ptr=0 → grants 0,1,2,3,0; each req_ready a single cycle; no grant while busy.
- Divide by zero: req2 A=0x0010 B=0x0000 fun=11 → alu_enable never asserted; rsp_valid at T+1, rsp_id=2, rsp_result=0, rsp_err=1.
- Backpressure: mul 0x0100*0x0100 with rsp_ready low for 5 cycles → rsp_valid and rsp_result=0x0000 (truncated) held stable; no req_ready during the stall; IDLE the cycle after rsp_ready=1.
- Missing flag: model unit holds alu_flag=0 → rsp_err=1, rsp_result equals sampled alu_out.
- Reset mid-op: rst low during WAIT → all outputs at reset values immediately, rr_ptr=0; after release, req1 is granted first when req0 is idle.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU operation scheduler.
// Holds the FSM state encoding, the function codes and the default operand width.
package alu_sched_pkg;

  localparam int ALU_WIDTH_DEF = 16;

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_SUB = 2'b01;
  localparam logic [1:0] FUN_MUL = 2'b10;
  localparam logic [1:0] FUN_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, wrapping.
// The pointer moves past the granted index only when the grant is actually accepted.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [PTR_W-1:0] rr_ptr;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant_idx   = PTR_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one arithmetic unit among NUM_REQ requesters with one operation in flight.
// Sequence: accept in IDLE, pulse the unit in ISSUE, sample in WAIT, hold the response in RESP.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int ALU_WIDTH = ALU_WIDTH_DEF,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ALU_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ALU_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]         req_fun,
  output logic [ALU_WIDTH-1:0]         alu_a,
  output logic [ALU_WIDTH-1:0]         alu_b,
  output logic [1:0]                   alu_fun,
  output logic                         alu_enable,
  input  logic [ALU_WIDTH-1:0]         alu_out,
  input  logic                         alu_flag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [ALU_WIDTH-1:0]         rsp_result,
  output logic                         rsp_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                 state;
  logic [NUM_REQ-1:0]     grant;
  logic [PTR_W-1:0]       grant_idx;
  logic                   any_req;
  logic                   accept;
  logic [ALU_WIDTH-1:0]   sel_a;
  logic [ALU_WIDTH-1:0]   sel_b;
  logic [1:0]             sel_fun;

  // Grants are only offered while idle and out of reset, so req_ready is one-hot or zero.
  assign accept    = rst && (state == IDLE) && any_req;
  assign req_ready = accept ? grant : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    sel_a   = req_a[int'(grant_idx)*ALU_WIDTH +: ALU_WIDTH];
    sel_b   = req_b[int'(grant_idx)*ALU_WIDTH +: ALU_WIDTH];
    sel_fun = req_fun[int'(grant_idx)*2 +: 2];
  end

  // Divide by zero never reaches the unit; it is answered straight from IDLE as an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fun    <= FUN_ADD;
      alu_enable <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            alu_fun <= sel_fun;
            rsp_id  <= ID_W'(grant_idx);
            if (sel_fun == FUN_DIV && sel_b == '0) begin
              rsp_result <= '0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              alu_enable <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          alu_enable <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          rsp_result <= alu_out;
          rsp_err    <= ~alu_flag;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
